triangle_rasterizer: RTL and testbench

- Sits directly downstream of the perspective divider array. Consumes the three projected card-corner vertices (x0,y0,x1,y1,x2,y2) that the divider array produces.
- Scans the triangle's screen-clipped bounding box in raster order and streams out only the pixels inside the triangle, over a valid/ready handshake, to the overlay/mask writer.
- Because the divider array has no valid output, the controller issues start_in once the divider latency has elapsed.

---
 rtl/triangle_rasterizer_if.sv | 24 ++
 rtl/triangle_rasterizer.sv | 232 +++++++++++++++++++++++
 tb/tb_triangle_rasterizer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_rasterizer_if.sv
// Pixel stream handshake between the triangle rasterizer and the overlay/mask writer.
// The rasterizer drives coordinates and valid; the writer drives ready.
interface triangle_rasterizer_if #(
   parameter int WIDTH = 9
);
   logic             pixel_valid_out;
   logic             pixel_ready_in;
   logic [WIDTH-1:0] pixel_x_out;
   logic [WIDTH-1:0] pixel_y_out;

   modport master (
      output pixel_valid_out,
      output pixel_x_out,
      output pixel_y_out,
      input  pixel_ready_in
   );

   modport slave (
      input  pixel_valid_out,
      input  pixel_x_out,
      input  pixel_y_out,
      output pixel_ready_in
   );
endinterface

// File: rtl/triangle_rasterizer.sv
// Scans a triangle's screen-clipped bounding box in raster order and streams out
// the covered pixels (either winding, edges inclusive) over a valid/ready handshake.
module triangle_rasterizer #(
   parameter int WIDTH    = 9,
   parameter int SIZE     = 6,
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_in,
   input  logic [WIDTH-1:0]      vertex_in [SIZE-1:0],
   triangle_rasterizer_if.master pix_if,
   output logic                  busy_out,
   output logic                  done_out
);

   localparam int DW = WIDTH + 1;
   localparam int AW = 2 * WIDTH + 2;
   localparam int EW = 2 * WIDTH + 3;
   localparam logic [WIDTH-1:0] XLIM = WIDTH'(SCREEN_W - 1);
   localparam logic [WIDTH-1:0] YLIM = WIDTH'(SCREEN_H - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_SCAN   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   function automatic logic signed [DW-1:0] diff(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   function automatic logic signed [EW-1:0] ext_e(input logic signed [DW-1:0] d);
      return $signed({{(EW-DW){d[DW-1]}}, d});
   endfunction

   function automatic logic signed [AW-1:0] ext_a(input logic signed [DW-1:0] d);
      return $signed({{(AW-DW){d[DW-1]}}, d});
   endfunction

   // Edge function of point (px,py) against the directed edge a->b.
   function automatic logic signed [EW-1:0] edge_val(
      input logic [WIDTH-1:0] px, input logic [WIDTH-1:0] py,
      input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] ya,
      input logic [WIDTH-1:0] xb, input logic [WIDTH-1:0] yb);
      return ext_e(diff(px, xa)) * ext_e(diff(yb, ya))
           - ext_e(diff(py, ya)) * ext_e(diff(xb, xa));
   endfunction

   function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
      logic [WIDTH-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [WIDTH-1:0] max3(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
      logic [WIDTH-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] vx_q [SIZE-1:0];
   logic [WIDTH-1:0] vx_d [SIZE-1:0];
   logic [WIDTH-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic [WIDTH-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
   logic [WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
   logic [WIDTH-1:0] px_q, px_d, py_q, py_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0]     bx_min_s, bx_max_raw_s, bx_max_s;
   logic [WIDTH-1:0]     by_min_s, by_max_raw_s, by_max_s;
   logic signed [AW-1:0] a2_s;
   logic                 empty_s;
   logic signed [EW-1:0] e0_s, e1_s, e2_s;
   logic                 inside_s;
   logic                 eval_s;

   // Setup-stage geometry: clipped bounding box and twice the signed area.
   always_comb begin
      bx_min_s     = min3(vx_q[0], vx_q[2], vx_q[4]);
      bx_max_raw_s = max3(vx_q[0], vx_q[2], vx_q[4]);
      by_min_s     = min3(vx_q[1], vx_q[3], vx_q[5]);
      by_max_raw_s = max3(vx_q[1], vx_q[3], vx_q[5]);
      bx_max_s     = (bx_max_raw_s > XLIM) ? XLIM : bx_max_raw_s;
      by_max_s     = (by_max_raw_s > YLIM) ? YLIM : by_max_raw_s;
      a2_s = ext_a(diff(vx_q[2], vx_q[0])) * ext_a(diff(vx_q[5], vx_q[1]))
           - ext_a(diff(vx_q[3], vx_q[1])) * ext_a(diff(vx_q[4], vx_q[0]));
      empty_s = (a2_s == '0) || (bx_min_s > bx_max_s) || (by_min_s > by_max_s);
   end

   // Scan-stage inside test for the current pointer; sign agreement accepts either winding.
   always_comb begin
      e0_s = edge_val(cx_q, cy_q, vx_q[0], vx_q[1], vx_q[2], vx_q[3]);
      e1_s = edge_val(cx_q, cy_q, vx_q[2], vx_q[3], vx_q[4], vx_q[5]);
      e2_s = edge_val(cx_q, cy_q, vx_q[4], vx_q[5], vx_q[0], vx_q[1]);
      inside_s = (!e0_s[EW-1] && !e1_s[EW-1] && !e2_s[EW-1]) ||
                 ((e0_s[EW-1] || e0_s == '0) &&
                  (e1_s[EW-1] || e1_s == '0) &&
                  (e2_s[EW-1] || e2_s == '0));
      eval_s = !valid_q || pix_if.pixel_ready_in;
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      vx_d    = vx_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymin_d  = ymin_q;
      ymax_d  = ymax_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      px_d    = px_q;
      py_d    = py_q;
      valid_d = valid_q && !pix_if.pixel_ready_in;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_in && !done_q) begin
               vx_d    = vertex_in;
               busy_d  = 1'b1;
               state_d = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            xmin_d = bx_min_s;
            xmax_d = bx_max_s;
            ymin_d = by_min_s;
            ymax_d = by_max_s;
            cx_d   = bx_min_s;
            cy_d   = by_min_s;
            // Nothing to emit and the output register is already empty, so finish now.
            if (empty_s) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (eval_s) begin
               px_d    = inside_s ? cx_q : px_q;
               py_d    = inside_s ? cy_q : py_q;
               valid_d = inside_s || (valid_q && !pix_if.pixel_ready_in);
               if (cx_q == xmax_q) begin
                  cx_d = xmin_q;
                  if (cy_q == ymax_q) begin
                     state_d = S_FINISH;
                  end else begin
                     cy_d = cy_q + ONE;
                  end
               end else begin
                  cx_d = cx_q + ONE;
               end
            end else begin
               state_d = S_SCAN;
            end
         end
         S_FINISH: begin
            if (!valid_q || pix_if.pixel_ready_in) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_FINISH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         for (int k = 0; k < SIZE; k++) begin
            vx_q[k] <= '0;
         end
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymin_q  <= '0;
         ymax_q  <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int k = 0; k < SIZE; k++) begin
            vx_q[k] <= vx_d[k];
         end
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymin_q  <= ymin_d;
         ymax_q  <= ymax_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         px_q    <= px_d;
         py_q    <= py_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign pix_if.pixel_valid_out = valid_q;
   assign pix_if.pixel_x_out     = px_q;
   assign pix_if.pixel_y_out     = py_q;
   assign busy_out               = busy_q;
   assign done_out               = done_q;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Randomized self-checking bench for triangle_rasterizer: a coverage model built from
// plain edge-function arithmetic feeds an expected-pixel queue checked on every handshake.
module tb_triangle_rasterizer;

   localparam int W = 9;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_in;
   logic [W-1:0] vertex_in [5:0];
   logic         busy_out;
   logic         done_out;

   triangle_rasterizer_if #(.WIDTH(W)) pix_if ();

   triangle_rasterizer #(
      .WIDTH(W), .SIZE(6), .SCREEN_W(320), .SCREEN_H(240)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_in  (start_in),
      .vertex_in (vertex_in),
      .pix_if    (pix_if),
      .busy_out  (busy_out),
      .done_out  (done_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int exp_q[$];
   int hs_count = 0;
   int ready_mode = 0;

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference coverage: every box pixel whose three edge functions share a sign (zero allowed).
   function automatic void build(input int x0, input int y0, input int x1, input int y1,
                                 input int x2, input int y2);
      int a2, xmn, xmx, ymn, ymx, e0, e1, e2;
      a2 = (x1 - x0) * (y2 - y0) - (y1 - y0) * (x2 - x0);
      if (a2 == 0) return;
      xmn = (x0 < x1) ? x0 : x1; xmn = (x2 < xmn) ? x2 : xmn;
      xmx = (x0 > x1) ? x0 : x1; xmx = (x2 > xmx) ? x2 : xmx;
      ymn = (y0 < y1) ? y0 : y1; ymn = (y2 < ymn) ? y2 : ymn;
      ymx = (y0 > y1) ? y0 : y1; ymx = (y2 > ymx) ? y2 : ymx;
      if (xmx > 319) xmx = 319;
      if (ymx > 239) ymx = 239;
      for (int y = ymn; y <= ymx; y++) begin
         for (int x = xmn; x <= xmx; x++) begin
            e0 = (x - x0) * (y1 - y0) - (y - y0) * (x1 - x0);
            e1 = (x - x1) * (y2 - y1) - (y - y1) * (x2 - x1);
            e2 = (x - x2) * (y0 - y2) - (y - y2) * (x0 - x2);
            if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
               exp_q.push_back(x * 1000 + y);
         end
      end
   endfunction

   // Output monitor: drives ready, checks holds and every accepted pixel against the model.
   initial begin
      bit pv, pr, r;
      int px, py, e, ax, ay, phase;
      pv = 1'b0; pr = 1'b0; px = 0; py = 0; phase = 0;
      pix_if.pixel_ready_in = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0;
         end else begin
            ax = int'(pix_if.pixel_x_out);
            ay = int'(pix_if.pixel_y_out);
            if (pv && !pr)
               check(pix_if.pixel_valid_out && ax == px && ay == py, "hold_stable",
                     ax * 1000 + ay, px * 1000 + py);
            case (ready_mode)
               0:       r = 1'b1;
               1:       begin r = (phase % 3 == 0); phase++; end
               default: r = 1'($urandom_range(0, 1));
            endcase
            pix_if.pixel_ready_in = r;
            if (pix_if.pixel_valid_out && r) begin
               hs_count++;
               check(ax < 320 && ay < 240, "on_screen", ax * 1000 + ay, 319239);
               if (exp_q.size() == 0) begin
                  check(1'b0, "extra_pixel", ax * 1000 + ay, -1);
               end else begin
                  e = exp_q.pop_front();
                  check(ax * 1000 + ay == e, "pixel_xy", ax * 1000 + ay, e);
               end
            end
            pv = pix_if.pixel_valid_out;
            pr = r;
            px = ax;
            py = ay;
         end
      end
   end

   task automatic set_vtx(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2);
      vertex_in[0] = 9'(x0); vertex_in[1] = 9'(y0);
      vertex_in[2] = 9'(x1); vertex_in[3] = 9'(y1);
      vertex_in[4] = 9'(x2); vertex_in[5] = 9'(y2);
   endtask

   task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int mode, input int exp_lat,
                          input bit poke);
      int n, c, d;
      bit seen;
      build(x0, y0, x1, y1, x2, y2);
      n = exp_q.size();
      hs_count = 0;
      ready_mode = mode;
      set_vtx(x0, y0, x1, y1, x2, y2);
      start_in = 1'b1;
      c = cyc;
      @(posedge clk); #1;
      start_in = 1'b0;
      seen = 1'b0;
      d = 0;
      for (int i = 0; i < 5000; i++) begin
         if (poke && i == 5) begin
            set_vtx(7, 7, 9, 7, 7, 9);
            start_in = 1'b1;
         end else begin
            start_in = 1'b0;
         end
         if (done_out) begin
            seen = 1'b1;
            d = cyc;
            break;
         end
         check(busy_out == 1'b1, "busy_during", int'(busy_out), 1);
         @(posedge clk); #1;
      end
      start_in = 1'b0;
      check(seen, "done_timeout", int'(seen), 1);
      if (exp_lat >= 0) check(d - c == exp_lat, "done_latency", d - c, exp_lat);
      check(busy_out == 1'b0, "busy_at_done", int'(busy_out), 0);
      check(exp_q.size() == 0, "missing_pixels", exp_q.size(), 0);
      check(hs_count == n, "pixel_count", hs_count, n);
      exp_q.delete();
      @(posedge clk); #1;
      check(done_out == 1'b0, "done_single", int'(done_out), 0);
   endtask

   initial begin
      int bx, by, dd;
      bit got;
      rst = 1'b1;
      start_in = 1'b0;
      set_vtx(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check(pix_if.pixel_valid_out == 1'b0, "rst_valid", int'(pix_if.pixel_valid_out), 0);
      check(pix_if.pixel_x_out == '0, "rst_x", int'(pix_if.pixel_x_out), 0);
      check(pix_if.pixel_y_out == '0, "rst_y", int'(pix_if.pixel_y_out), 0);
      check(busy_out == 1'b0, "rst_busy", int'(busy_out), 0);
      check(done_out == 1'b0, "rst_done", int'(done_out), 0);
      rst = 1'b0;

      // Hand-computed expectations that pin the reference model.
      build(0, 0, 4, 0, 0, 4);
      check(exp_q.size() == 15, "model_count", exp_q.size(), 15);
      check(exp_q[0] == 0, "model_first", exp_q[0], 0);
      check(exp_q[exp_q.size()-1] == 4, "model_last", exp_q[exp_q.size()-1], 4);
      exp_q.delete();
      build(0, 0, 2, 2, 4, 4);
      check(exp_q.size() == 0, "model_collinear", exp_q.size(), 0);
      exp_q.delete();
      build(300, 230, 400, 230, 300, 300);
      check(exp_q.size() == 200, "model_clip_count", exp_q.size(), 200);
      check(exp_q[0] == 300230, "model_clip_first", exp_q[0], 300230);
      check(exp_q[exp_q.size()-1] == 319239, "model_clip_last", exp_q[exp_q.size()-1], 319239);
      exp_q.delete();

      run_tri(0, 0, 4, 0, 0, 4, 0, 28, 1'b0);
      run_tri(0, 0, 0, 4, 4, 0, 0, 28, 1'b1);
      run_tri(0, 0, 2, 2, 4, 4, 0, 2, 1'b0);
      check(hs_count == 0, "collinear_silent", hs_count, 0);
      run_tri(300, 230, 400, 230, 300, 300, 0, -1, 1'b0);
      run_tri(0, 0, 4, 0, 0, 4, 1, -1, 1'b0);

      // Abort mid-scan with reset after five accepted pixels.
      build(0, 0, 4, 0, 0, 4);
      hs_count = 0;
      ready_mode = 0;
      set_vtx(0, 0, 4, 0, 0, 4);
      start_in = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (hs_count >= 5) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check(got, "reset_wait_timeout", hs_count, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      check(pix_if.pixel_valid_out == 1'b0, "abort_valid", int'(pix_if.pixel_valid_out), 0);
      check(busy_out == 1'b0, "abort_busy", int'(busy_out), 0);
      check(done_out == 1'b0, "abort_done", int'(done_out), 0);
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check(done_out == 1'b0 && busy_out == 1'b0, "abort_quiet", int'(done_out), 0);
      end
      run_tri(0, 0, 4, 0, 0, 4, 0, 28, 1'b0);

      // Randomized triangles, some collinear, near screen edges and under random backpressure.
      for (int t = 0; t < 25; t++) begin
         bx = $urandom_range(0, 330);
         by = $urandom_range(0, 250);
         if (t % 7 == 0) begin
            dd = $urandom_range(0, 6);
            run_tri(bx, by, bx + dd, by + dd, bx + 2 * dd, by + 2 * dd,
                    $urandom_range(0, 2), 2, 1'b0);
         end else begin
            run_tri(bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                    bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                    bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                    $urandom_range(0, 2), -1, 1'b0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
